// File: rtl/cmp_arbiter_pkg.sv
// cmp_arbiter_pkg
// Shared definitions for the execute-stage comparator arbiter:
//   - cmp_func_e      : comparator function encodings (bit0 negate,
//                       bit1 unsigned, bit2 less-than / clear = equal)
//   - ID_BRANCH/ID_ALU: requester ids carried through the pipeline
//   - cmp_arb_entry_t : stage-1 / hold entry {valid, id, tag}
//   - cmp_eval        : combinational comparison used by the cmp unit
// Entry tags are CMP_ARB_TAG_W bits wide; a wider top-level TAG_W needs
// this constant raised to match.
package cmp_arbiter_pkg;

  localparam int CMP_ARB_TAG_W = 4;

  typedef enum logic [2:0] {
    EQ  = 3'b000,
    NE  = 3'b001,
    LT  = 3'b100,
    GE  = 3'b101,
    LTU = 3'b110,
    GEU = 3'b111
  } cmp_func_e;

  localparam logic ID_BRANCH = 1'b0;
  localparam logic ID_ALU    = 1'b1;

  typedef struct packed {
    logic                     valid;
    logic                     id;
    logic [CMP_ARB_TAG_W-1:0] tag;
  } cmp_arb_entry_t;

  // Both operands are widened to 33 bits so a single signed compare covers
  // the signed (sign-extended) and unsigned (zero-extended) cases.
  function automatic logic cmp_eval(input logic [31:0] a,
                                    input logic [31:0] b,
                                    input logic [2:0]  func);
    logic [32:0] ax;
    logic [32:0] bx;
    logic        outcome;
    ax = func[1] ? {1'b0, a} : {a[31], a};
    bx = func[1] ? {1'b0, b} : {b[31], b};
    if (func[2]) outcome = ($signed(ax) < $signed(bx));
    else         outcome = (a == b);
    return outcome ^ func[0];
  endfunction

endpackage

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if
// One requester's connection to the comparator arbiter: request channel
// (valid/ready, operands, function, tag) and response channel
// (valid/ready, result, tag).
//   modport master : the requester (branch unit or ALU slt path)
//   modport slave  : the arbiter
interface cmp_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [2:0]       req_func;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_func, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_func, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );
endinterface

// File: rtl/cmp.sv
// cmp
// The core's single registered comparator: evaluates func on a/b and
// presents the outcome one clock later.
// Ports: clk, reset (sync, active-high), a, b (32), func (3), result (1).
module cmp
  import cmp_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  func,
  output logic        result
);

  always_ff @(posedge clk) begin
    if (reset) result <= 1'b0;
    else       result <= cmp_eval(a, b, func);
  end

endmodule

// File: rtl/cmp_arbiter_rr.sv
// cmp_arb_rr
// Two-way picker for the comparator arbiter. Takes the eligible mask and
// returns a one-hot (or zero) grant.
//   Default build : round-robin on ties; an internal `last` register holds
//                   the most recent winner and resets to 1 so requester 0
//                   takes the first tie.
//   CMP_ARB_FIXED_PRIO_EN defined : requester 0 always wins a tie; no state,
//                   so the clock/reset ports are not present.
// Ports: clk, reset (round-robin build only), eligible[1:0], grant[1:0].
module cmp_arb_rr (
`ifndef CMP_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

`ifdef CMP_ARB_FIXED_PRIO_EN
  assign grant = {eligible[1] & ~eligible[0], eligible[0]};
`else
  logic last;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant = eligible;
    if (&eligible) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset)       last <= 1'b1;
    else if (|grant) last <= grant[1];
  end
`endif

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter
// Shares the registered comparator between the branch unit (port 0) and
// the ALU set-less-than path (port 1). One request is granted per cycle,
// its result comes back one cycle later on the owner's response channel
// with the owner's tag, and is parked in a per-port hold register if the
// owner is not ready to take it.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   p0, p1     : cmp_arbiter_if.slave for requester 0 (branch) / 1 (ALU)
// Configuration: define CMP_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins ties); default build is round-robin.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int TAG_W = CMP_ARB_TAG_W
) (
  input  logic         clk,
  input  logic         reset,
  cmp_arbiter_if.slave p0,
  cmp_arbiter_if.slave p1
);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      req_a    [2];
  logic [31:0]      req_b    [2];
  logic [2:0]       req_func [2];
  logic [TAG_W-1:0] req_tag  [2];

  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             winner;
  logic [1:0]       inflight;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_result;
  logic [TAG_W-1:0] rsp_tag  [2];

  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic [2:0]       cmp_func;
  logic             cmp_result;

  cmp_arb_entry_t   s1_q;
  cmp_arb_entry_t   hold_q [2];
  logic [1:0]       hold_res_q;

  assign req_valid   = {p1.req_valid, p0.req_valid};
  assign rsp_ready   = {p1.rsp_ready, p0.rsp_ready};
  assign req_a[0]    = p0.req_a;
  assign req_a[1]    = p1.req_a;
  assign req_b[0]    = p0.req_b;
  assign req_b[1]    = p1.req_b;
  assign req_func[0] = p0.req_func;
  assign req_func[1] = p1.req_func;
  assign req_tag[0]  = p0.req_tag;
  assign req_tag[1]  = p1.req_tag;

  assign p0.req_ready  = grant[ID_BRANCH];
  assign p1.req_ready  = grant[ID_ALU];
  assign p0.rsp_valid  = rsp_valid[ID_BRANCH];
  assign p1.rsp_valid  = rsp_valid[ID_ALU];
  assign p0.rsp_result = rsp_result[ID_BRANCH];
  assign p1.rsp_result = rsp_result[ID_ALU];
  assign p0.rsp_tag    = rsp_tag[ID_BRANCH];
  assign p1.rsp_tag    = rsp_tag[ID_ALU];

  // A requester may issue only when it has no outstanding response, or its
  // outstanding one is leaving straight from the comparator this cycle.
  // Everything is masked during reset so a result caught in flight by a
  // reset is never shown.
  always_comb begin
    inflight   = '0;
    eligible   = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_tag[0] = '0;
    rsp_tag[1] = '0;
    for (int n = 0; n < 2; n++) begin
      inflight[n] = s1_q.valid && (s1_q.id == 1'(n));
      eligible[n] = !reset && req_valid[n] && !hold_q[n].valid &&
                    !(inflight[n] && !rsp_ready[n]);
      if (!reset) begin
        if (hold_q[n].valid) begin
          rsp_valid[n]  = 1'b1;
          rsp_result[n] = hold_res_q[n];
          rsp_tag[n]    = TAG_W'(hold_q[n].tag);
        end else if (inflight[n]) begin
          rsp_valid[n]  = 1'b1;
          rsp_result[n] = cmp_result;
          rsp_tag[n]    = TAG_W'(s1_q.tag);
        end
      end
    end
  end

  cmp_arb_rr u_pick (
`ifndef CMP_ARB_FIXED_PRIO_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .eligible (eligible),
    .grant    (grant)
  );

  assign winner   = grant[ID_ALU];
  assign cmp_a    = winner ? req_a[1]    : req_a[0];
  assign cmp_b    = winner ? req_b[1]    : req_b[0];
  assign cmp_func = winner ? req_func[1] : req_func[0];

  cmp u_cmp (
    .clk    (clk),
    .reset  (reset),
    .a      (cmp_a),
    .b      (cmp_b),
    .func   (cmp_func),
    .result (cmp_result)
  );

  // Stage 1 tracks whose result the comparator will present next cycle.
  // A result the owner refuses is parked in that owner's hold register;
  // eligibility guarantees a hold is never overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      hold_q[0]  <= '0;
      hold_q[1]  <= '0;
      hold_res_q <= '0;
    end else begin
      s1_q.valid <= |grant;
      s1_q.id    <= winner;
      s1_q.tag   <= CMP_ARB_TAG_W'(winner ? req_tag[1] : req_tag[0]);
      for (int n = 0; n < 2; n++) begin
        if (hold_q[n].valid) begin
          if (rsp_ready[n]) hold_q[n].valid <= 1'b0;
        end else if (inflight[n] && !rsp_ready[n]) begin
          hold_q[n]     <= s1_q;
          hold_res_q[n] <= cmp_result;
        end
      end
    end
  end

endmodule
